bf16_acc_stage: RTL and testbench

//  Downstream stage of iv_fp_mul: takes one bfloat16 product plus its 2-bit error per handshake and

---
 rtl/bf16_acc_stage.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_bf16_acc_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bf16_acc_stage.sv
`timescale 1ns/1ps
// bf16_acc_stage: sums a packet of bfloat16 products (ended by in_last) into a bf16
// accumulator and returns the sum, a sticky error code and the product count.
module bf16_acc_stage #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ERROR_WIDTH = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [ERROR_WIDTH-1:0] in_error,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [ERROR_WIDTH-1:0] out_error,
  output logic [CNT_W-1:0]       out_count
);

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MAN_W  = 7;
  localparam int unsigned SIG_W  = MAN_W + 1;
  localparam int unsigned ALN_W  = SIG_W + 3;  // significand plus guard, round, sticky
  localparam int unsigned SUM_W  = ALN_W + 1;
  localparam int unsigned RSIG_W = SIG_W + 1;
  localparam int unsigned EW     = EXP_W + 2;  // exponent with carry headroom and sign
  localparam int unsigned LZ_W   = 4;
  localparam logic [DATA_WIDTH-1:0] QNAN = DATA_WIDTH'(16'h7FC0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic                   accept, ld_out, clr_pkt;
  logic                   in_ready_d, out_valid_d;
  logic                   in_ready_q, out_valid_q;
  logic [DATA_WIDTH-1:0]  out_data_q;
  logic [ERROR_WIDTH-1:0] out_error_q;
  logic [CNT_W-1:0]       out_count_q;

  logic [DATA_WIDTH-1:0]  acc_q, op_q;
  logic                   last_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   inv_q, ovf_q, unf_q;
  logic                   inv_d, ovf_d, unf_d;
  logic [ERROR_WIDTH-1:0] err_enc;

  logic                   a_sgn, b_sgn, a_nan, b_nan, a_inf, b_inf, b_big, big_sgn;
  logic [EXP_W-1:0]       a_exp, b_exp, big_exp, sml_exp, shamt;
  logic [MAN_W-1:0]       a_man, b_man, big_man, sml_man;
  logic [ALN_W-1:0]       big_sig, sml_sig, sml_aln;
  logic                   spec, spec_inv;
  logic [DATA_WIDTH-1:0]  spec_val;

  logic [ALN_W-1:0]       big_sig_q, sml_aln_q;
  logic [EXP_W-1:0]       exp_q;
  logic                   sgn_q, sub_q, spec_q, spec_inv_q;
  logic [DATA_WIDTH-1:0]  spec_val_q;
  logic [SUM_W-1:0]       sum_q;

  logic [LZ_W-1:0]        lz;
  logic [ALN_W-1:0]       nrm;
  logic [EW-1:0]          nexp, rexp;
  logic                   rnd_up;
  logic [RSIG_W-1:0]      rsig;
  logic [MAN_W-1:0]       rman;
  logic [DATA_WIDTH-1:0]  res;
  logic                   n_inv, n_ovf, n_unf;

  assign accept = in_valid && in_ready_q && (state_q == S_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ALIGN;
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  state_d = last_q ? S_DONE : S_IDLE;
      S_DONE:  if (out_valid_q && out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: next values of the handshake registers and datapath strobes
  always_comb begin
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    ld_out      = (state_q == S_NORM) && last_q;
    clr_pkt     = (state_q == S_DONE) && out_valid_q && out_ready;
  end

  // ALIGN: classify specials, order operands by magnitude, align the smaller one
  always_comb begin
    a_sgn = acc_q[DATA_WIDTH-1];
    a_exp = acc_q[DATA_WIDTH-2 -: EXP_W];
    a_man = acc_q[MAN_W-1:0];
    b_sgn = op_q[DATA_WIDTH-1];
    b_exp = op_q[DATA_WIDTH-2 -: EXP_W];
    b_man = op_q[MAN_W-1:0];
    a_nan = (a_exp == '1) && (a_man != '0);
    b_nan = (b_exp == '1) && (b_man != '0);
    a_inf = (a_exp == '1) && (a_man == '0);
    b_inf = (b_exp == '1) && (b_man == '0);
    b_big = {b_exp, b_man} > {a_exp, a_man};
    if (b_big) begin
      big_sgn = b_sgn; big_exp = b_exp; big_man = b_man;
      sml_exp = a_exp; sml_man = a_man;
    end else begin
      big_sgn = a_sgn; big_exp = a_exp; big_man = a_man;
      sml_exp = b_exp; sml_man = b_man;
    end
    big_sig = (big_exp == '0) ? '0 : {1'b1, big_man, 3'b000};
    sml_sig = (sml_exp == '0) ? '0 : {1'b1, sml_man, 3'b000};
    shamt   = big_exp - sml_exp;
    if (shamt >= EXP_W'(ALN_W)) begin
      sml_aln = {{(ALN_W-1){1'b0}}, |sml_sig};
    end else begin
      sml_aln    = sml_sig >> shamt;
      sml_aln[0] = sml_aln[0] | (|(sml_sig & ~({ALN_W{1'b1}} << shamt)));
    end
    spec     = 1'b0;
    spec_inv = 1'b0;
    spec_val = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (a_sgn != b_sgn))) begin
      spec = 1'b1; spec_inv = 1'b1; spec_val = QNAN;
    end else if (a_inf) begin
      spec = 1'b1; spec_val = acc_q;
    end else if (b_inf) begin
      spec = 1'b1; spec_val = op_q;
    end
  end

  // NORM: normalise, round to nearest even, then range-check the exponent
  always_comb begin
    lz = LZ_W'(ALN_W);
    for (int i = 0; i < int'(ALN_W); i++) begin
      if (sum_q[i]) lz = LZ_W'(int'(ALN_W) - 1 - i);
    end
    if (sum_q[SUM_W-1]) begin
      nrm  = {sum_q[SUM_W-1:2], sum_q[1] | sum_q[0]};
      nexp = EW'(exp_q) + EW'(1);
    end else begin
      nrm  = sum_q[ALN_W-1:0] << lz;
      nexp = EW'(exp_q) - EW'(lz);
    end
    rnd_up = nrm[2] && (nrm[1] || nrm[0] || nrm[3]);
    rsig   = {1'b0, nrm[ALN_W-1:3]} + RSIG_W'(rnd_up);
    if (rsig[RSIG_W-1]) begin
      rman = '0;
      rexp = nexp + EW'(1);
    end else begin
      rman = rsig[MAN_W-1:0];
      rexp = nexp;
    end
    n_inv = 1'b0;
    n_ovf = 1'b0;
    n_unf = 1'b0;
    if (spec_q) begin
      res   = spec_val_q;
      n_inv = spec_inv_q;
    end else if (sum_q == '0) begin
      res = '0;
    end else if (!rexp[EW-1] && (rexp >= EW'(255))) begin
      res   = {sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      n_ovf = 1'b1;
    end else if (rexp[EW-1] || (rexp == '0)) begin
      res   = '0;
      n_unf = 1'b1;
    end else begin
      res = {sgn_q, rexp[EXP_W-1:0], rman};
    end
  end

  // Sticky error flags: multiplier errors at accept, arithmetic errors at NORM
  always_comb begin
    inv_d = inv_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (accept) begin
      inv_d = inv_d | (in_error == ERROR_WIDTH'(3));
      ovf_d = ovf_d | (in_error == ERROR_WIDTH'(1));
      unf_d = unf_d | (in_error == ERROR_WIDTH'(2));
    end
    if (state_q == S_NORM) begin
      inv_d = inv_d | n_inv;
      ovf_d = ovf_d | n_ovf;
      unf_d = unf_d | n_unf;
    end
    if (clr_pkt) begin
      inv_d = 1'b0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (inv_d)      err_enc = ERROR_WIDTH'(3);
    else if (ovf_d) err_enc = ERROR_WIDTH'(1);
    else if (unf_d) err_enc = ERROR_WIDTH'(2);
    else            err_enc = '0;
  end

  // Handshake and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_error_q <= '0;
      out_count_q <= '0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      if (ld_out) begin
        out_data_q  <= res;
        out_error_q <= err_enc;
        out_count_q <= cnt_q;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      op_q       <= '0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      inv_q      <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      big_sig_q  <= '0;
      sml_aln_q  <= '0;
      exp_q      <= '0;
      sgn_q      <= 1'b0;
      sub_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_inv_q <= 1'b0;
      spec_val_q <= '0;
      sum_q      <= '0;
    end else begin
      inv_q <= inv_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (accept) begin
        op_q   <= in_data;
        last_q <= in_last;
        cnt_q  <= cnt_q + CNT_W'(1);
      end
      if (state_q == S_ALIGN) begin
        big_sig_q  <= big_sig;
        sml_aln_q  <= sml_aln;
        exp_q      <= big_exp;
        sgn_q      <= big_sgn;
        sub_q      <= a_sgn ^ b_sgn;
        spec_q     <= spec;
        spec_inv_q <= spec_inv;
        spec_val_q <= spec_val;
      end
      if (state_q == S_ADD) begin
        sum_q <= sub_q ? ({1'b0, big_sig_q} - {1'b0, sml_aln_q})
                       : ({1'b0, big_sig_q} + {1'b0, sml_aln_q});
      end
      if (state_q == S_NORM) acc_q <= res;
      if (clr_pkt) begin
        acc_q <= '0;
        cnt_q <= '0;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_error = out_error_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_bf16_acc_stage.sv
`timescale 1ns/1ps
// tb_bf16_acc_stage: directed packets with hand-computed bf16 sums, error codes and counts.
module tb_bf16_acc_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_error;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_error;
  logic [7:0]  out_count;

  int checks   = 0;
  int failures = 0;

  bf16_acc_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_error  (in_error),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_error (out_error),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one product, wait (bounded) for in_ready, then scramble the inputs after accept
  task automatic send(input logic [15:0] d, input logic [1:0] e, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_error = e;
    in_last  = l;
    while (!in_ready && n < 16) begin
      tick();
      n++;
    end
    chk("send_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = 16'hFFFF;
    in_error = 2'b11;
    in_last  = ~l;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (!out_valid && n < 16) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic get(input string tag, input logic [15:0] d, input logic [1:0] e,
                     input logic [7:0] c);
    wait_out(tag);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_err"}, 32'(out_error), 32'(e));
    chk({tag, "_count"}, 32'(out_count), 32'(c));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_hs_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
    chk({tag, "_err"}, 32'(out_error), 32'd0);
    chk({tag, "_count"}, 32'(out_count), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_error  = 2'b00;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    tick();
    chk_idle("post_rst");

    // T1: 1.0 + 2.0 = 3.0, out_valid in the 4th cycle after the last accept
    send(16'h3F80, 2'b00, 1'b0);
    send(16'h4000, 2'b00, 1'b1);
    tick();
    tick();
    chk("t1_lat_early", 32'(out_valid), 32'd0);
    tick();
    chk("t1_lat", 32'(out_valid), 32'd1);
    get("t1", 16'h4040, 2'b00, 8'd2);

    // T2: cancellation and round-to-nearest-even
    send(16'h3F80, 2'b00, 1'b0);
    send(16'hBF80, 2'b00, 1'b1);
    get("t2_cancel", 16'h0000, 2'b00, 8'd2);
    send(16'h3F81, 2'b00, 1'b0);
    send(16'h3B80, 2'b00, 1'b1);
    get("t2_tie_up", 16'h3F82, 2'b00, 8'd2);
    send(16'h3F80, 2'b00, 1'b0);
    send(16'h3B80, 2'b00, 1'b1);
    get("t2_tie_even", 16'h3F80, 2'b00, 8'd2);

    // T3: overflow, NaN operand, inf minus inf, underflow
    send(16'h7F7F, 2'b00, 1'b0);
    send(16'h7F7F, 2'b00, 1'b1);
    get("t3_ovf", 16'h7F80, 2'b01, 8'd2);
    send(16'h7FC1, 2'b11, 1'b0);
    send(16'h3F80, 2'b00, 1'b1);
    get("t3_nan", 16'h7FC0, 2'b11, 8'd2);
    send(16'h7F80, 2'b00, 1'b0);
    send(16'hFF80, 2'b00, 1'b1);
    get("t3_inf_inf", 16'h7FC0, 2'b11, 8'd2);
    send(16'h0081, 2'b00, 1'b0);
    send(16'h8080, 2'b00, 1'b1);
    get("t3_unf", 16'h0000, 2'b10, 8'd2);

    // T4: sticky multiplier underflow on the first of three products, 1+2+3 = 6
    send(16'h3F80, 2'b10, 1'b0);
    send(16'h4000, 2'b00, 1'b0);
    send(16'h4040, 2'b00, 1'b1);
    get("t4", 16'h40C0, 2'b10, 8'd3);

    // T5: result held under back-pressure, pending product not accepted
    send(16'h4000, 2'b00, 1'b1);
    wait_out("t5");
    in_valid = 1'b1;
    in_data  = 16'h3F80;
    in_error = 2'b00;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_valid", 32'(out_valid), 32'd1);
      chk("t5_hold_ready", 32'(in_ready), 32'd0);
      chk("t5_hold_data", 32'(out_data), 32'h4000);
      chk("t5_hold_count", 32'(out_count), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t5_rel_valid", 32'(out_valid), 32'd0);
    chk("t5_rel_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    get("t5_next", 16'h3F80, 2'b00, 8'd1);

    // T6: reset while in ADD, then reset while holding a result
    send(16'h3F80, 2'b00, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    chk("t6_add_rst_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    tick();
    chk_idle("t6_add");
    send(16'h4000, 2'b00, 1'b1);
    wait_out("t6_done_pre");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk_idle("t6_done");
    send(16'h4040, 2'b00, 1'b1);
    get("t6_after", 16'h4040, 2'b00, 8'd1);

    // Count wraps after 256 products without raising an error
    for (int i = 0; i < 256; i++) begin
      send(16'h0000, 2'b00, (i == 255));
    end
    get("wrap", 16'h0000, 2'b00, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
